// File: rtl/arb_mux_pkg.sv
// Shared types and helpers for the arb_mux round-robin output mux.
package arb_mux_pkg;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr, wrapping modulo N.
module rr_arbiter
   import arb_mux_pkg::*;
#(
   parameter int N    = 3,
   parameter int SELW = clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   input  logic            en,
   output logic [N-1:0]    gnt,
   output logic [SELW-1:0] gnt_idx,
   output logic            any
);

   always_comb begin
      int k;
      logic [SELW-1:0] kk;
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      for (int off = 0; off < N; off++) begin
         // ptr is always below N, so one subtraction keeps the index in range
         k = int'(ptr) + off;
         if (k >= N) k = k - N;
         kk = SELW'(k);
         if (en && !any && req[kk]) begin
            any     = 1'b1;
            gnt[kk] = 1'b1;
            gnt_idx = kk;
         end
      end
   end

endmodule

// File: rtl/arb_mux.sv
// N-channel valid/ready mux with round-robin arbitration and registered output.
// Build option ARB_MUX_LOCK_EN adds in_last and burst locking to one channel.
module arb_mux
   import arb_mux_pkg::*;
#(
   parameter int N    = 3,
   parameter int W    = 16,
   parameter int SELW = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N*W-1:0]    in_data,
   input  logic [N-1:0]      in_valid,
   output logic [N-1:0]      in_ready,
`ifdef ARB_MUX_LOCK_EN
   input  logic [N-1:0]      in_last,
`endif
   output logic [W-1:0]      out_data,
   output logic [SELW-1:0]   out_sel,
   output logic              out_valid,
   input  logic              out_ready
);

   // state      | meaning
   // ARB_IDLE   | normal round-robin arbitration every beat
   // ARB_LOCKED | mid-burst, only channel lock_q may be granted

   logic [W-1:0]    out_data_q, out_data_d;
   logic [SELW-1:0] out_sel_q, out_sel_d;
   logic            out_valid_q, out_valid_d;
   logic [SELW-1:0] ptr_q, ptr_d;
   logic [N-1:0]    req, gnt;
   logic [SELW-1:0] gnt_idx, next_idx;
   logic            load, en, any;

   assign load = ~out_valid_q | out_ready;
   assign en   = load & ~rst;

`ifdef ARB_MUX_LOCK_EN
   arb_state_e      state_q, state_d;
   logic [SELW-1:0] lock_q, lock_d;

   assign req = (state_q == ARB_LOCKED) ? (in_valid & (N'(1) << lock_q)) : in_valid;
`else
   assign req = in_valid;
`endif

   rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
      .req     (req),
      .ptr     (ptr_q),
      .en      (en),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any     (any)
   );

   assign in_ready = gnt;
   assign next_idx = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);

   always_comb begin
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      if (load) begin
         if (any) begin
            out_data_d  = in_data[gnt_idx*W +: W];
            out_sel_d   = gnt_idx;
            out_valid_d = 1'b1;
            ptr_d       = next_idx;
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

`ifdef ARB_MUX_LOCK_EN
   always_comb begin
      state_d = state_q;
      lock_d  = lock_q;
      if (any) begin
         if (state_q == ARB_IDLE && !in_last[gnt_idx]) begin
            state_d = ARB_LOCKED;
            lock_d  = gnt_idx;
         end else if (state_q == ARB_LOCKED && in_last[gnt_idx]) begin
            state_d = ARB_IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         lock_q  <= '0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data_q  <= '0;
         out_sel_q   <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         out_valid_q <= out_valid_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;
   assign out_valid = out_valid_q;

endmodule
